// File: rtl/piso_if.sv
// piso_if: valid/ready word intake for the piso_tx serialiser.
// The master drives a word and valid; the slave answers with ready.
interface piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             valid;
    logic             ready;

    modport master (
        output din,
        output valid,
        input  ready
    );

    modport slave (
        input  din,
        input  valid,
        output ready
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: MSB-first parallel-to-serial transmitter feeding a sipo.
// Define PISO_PARITY_EN to append an even-parity bit after the data.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    piso_if.slave  up,
    input  logic   en,
    output logic   sd,
    output logic   se,
    output logic   done,
    output logic   busy
);
`ifdef PISO_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] CNT_TOP = CW'(NB - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        last     = (state_q == SHIFT) && en && (cnt_q == '0);
        up.ready = !rst && ((state_q == IDLE) || last);
        accept   = up.valid && up.ready;
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        sd       = 1'b0;
        se       = 1'b0;
`ifdef PISO_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
            end
            SHIFT: begin
                se = en;
                sd = sh_q[WIDTH-1];
`ifdef PISO_PARITY_EN
                if (cnt_q == '0) sd = par_q;
`endif
                if (en) begin
                    sh_d = {sh_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
        endcase
        // Accept overrides the final-bit update for back-to-back words.
        if (accept) begin
            sh_d    = up.din;
            cnt_d   = CNT_TOP;
            state_d = SHIFT;
`ifdef PISO_PARITY_EN
            par_d   = ^up.din;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`endif

    assign done = done_q;
    assign busy = (state_q == SHIFT);
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized and directed bench for piso_tx.
// A word-level model predicts every output and the downstream sipo word.
module tb_piso_tx;
    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic sd, se, done, busy;

    piso_if #(.WIDTH(WIDTH)) bus ();

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .up   (bus),
        .en   (en),
        .sd   (sd),
        .se   (se),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int               m_left = 0;
    logic [WIDTH-1:0] m_word = '0;
    bit               m_done = 1'b0;
    logic [NB-1:0]    m_last = '0;
    logic [NB-1:0]    sipo   = '0;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h @%0t",
                      tag, got, exp, $time);
    endtask

    function automatic logic bit_of(logic [WIDTH-1:0] w, int k);
        if (k < WIDTH) return w[WIDTH-1-k];
        return ^w;
    endfunction

    function automatic logic [NB-1:0] word_of(logic [WIDTH-1:0] w);
        logic [NB-1:0] r;
        for (int k = 0; k < NB; k++) r[NB-1-k] = bit_of(w, k);
        return r;
    endfunction

    task automatic cyc(bit v, logic [WIDTH-1:0] d, bit e);
        bit e_busy, e_se, e_sd, e_ready;
        bus.valid = v;
        bus.din   = d;
        en        = e;
        @(negedge clk);
        e_busy  = (m_left > 0);
        e_se    = e_busy && e;
        e_sd    = e_busy ? bit_of(m_word, NB - m_left) : 1'b0;
        e_ready = !e_busy || (e && m_left == 1);
        check("ready", 32'(bus.ready), 32'(e_ready));
        check("busy", 32'(busy), 32'(e_busy));
        check("se", 32'(se), 32'(e_se));
        check("sd", 32'(sd), 32'(e_sd));
        check("done", 32'(done), 32'(m_done));
        if (m_done) check("sipo", 32'(sipo), 32'(m_last));
        if (se) sipo = {sipo[NB-2:0], sd};
        m_done = 1'b0;
        if (e_se) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_last = word_of(m_word);
            end
        end
        if (v && e_ready) begin
            m_word = d;
            m_left = NB;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.valid = 1'b0;
        en = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_se", 32'(se), 32'd0);
        check("rst_sd", 32'(sd), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        m_left = 0;
        m_done = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rel_ready", 32'(bus.ready), 32'd1);
    endtask

    task automatic send(logic [WIDTH-1:0] w, int idle);
        cyc(1'b1, w, 1'b1);
        for (int i = 0; i < NB + idle; i++) cyc(1'b0, '0, 1'b1);
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.din   = '0;
        @(posedge clk);
        #1;
        do_reset();

        send(8'hA5, 2);
        send(8'h07, 2);

        cyc(1'b1, 8'hA5, 1'b1);
        for (int i = 1; i <= NB; i++) cyc(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < NB + 2; i++) cyc(1'b0, '0, 1'b1);

        cyc(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);
        for (int i = 0; i < NB; i++) cyc(1'b0, '0, 1'b1);

        cyc(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        do_reset();
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1);
        send(8'h81, 2);

        for (int i = 0; i < 400; i++)
            cyc(($urandom % 3) != 0, WIDTH'($urandom),
                ($urandom % 4) != 0);
        cyc(1'b1, WIDTH'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
        do_reset();
        for (int i = 0; i < 100; i++)
            cyc(1'b1, WIDTH'($urandom), ($urandom % 5) != 0);
        for (int i = 0; i < 3 * NB; i++) cyc(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
